// File: rtl/sr_ctrl_pkg.sv
// Shared types for the SR latch sequencer: FSM state encoding, operation
// encoding and the request arbitration helper.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        INIT_PULSE = 3'd1,
        IDLE       = 3'd2,
        PULSE      = 3'd3,
        GUARD      = 3'd4
    } state_e;

    typedef enum logic {
        OP_RESET = 1'b0,
        OP_SET   = 1'b1
    } op_e;

    // Resolves a request pair to one op; the losing request is simply dropped.
    function automatic op_e pick_op(input logic set_req, input logic reset_req,
                                    input logic prio_set);
        if (set_req && reset_req) begin
            return prio_set ? OP_SET : OP_RESET;
        end
        return set_req ? OP_SET : OP_RESET;
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter with a registered expire flag that is high during the
// last cycle of a phase of `value` cycles started by a load.
module sr_pulse_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expire_q, expire_d;

    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load) begin
            cnt_d    = value;
            expire_d = (value <= W'(1));
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - W'(1);
            // Flag goes high for the cycle in which the count reads 1.
            expire_d = (cnt_q == W'(2));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer turning set/reset requests into exclusive, fixed-width s/r pulses
// with a guard gap, plus a shadow copy of the external latch state.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned GUARD_CYC = 1,
    parameter bit          PRIO_SET  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic reset_req,
    output logic req_ready,
    output logic s,
    output logic r,
    output logic q,
    output logic qbar,
    output logic done
);

    localparam int unsigned MAX_CYC = (PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PULSE_VAL = CW'(PULSE_CYC);
    localparam logic [CW-1:0] GUARD_VAL = CW'(GUARD_CYC);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    op_e           req_op;
    logic          op_valid_q, op_valid_d;
    logic          q_q, q_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_expire;

    sr_pulse_timer #(
        .W(CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        op_valid_d = op_valid_q;
        q_d        = q_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_value  = PULSE_VAL;
        req_op     = pick_op(set_req, reset_req, PRIO_SET);

        case (state_q)
            INIT: begin
                state_d  = INIT_PULSE;
                tmr_load = 1'b1;
            end
            INIT_PULSE: begin
                if (tmr_expire) begin
                    if (GUARD_CYC != 0) begin
                        state_d   = GUARD;
                        tmr_load  = 1'b1;
                        tmr_value = GUARD_VAL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                if (set_req || reset_req) begin
                    // A request for the state the latch already holds completes at once.
                    if ((req_op == OP_SET) == q_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = PULSE;
                        op_d       = req_op;
                        op_valid_d = 1'b1;
                        q_d        = (req_op == OP_SET);
                        tmr_load   = 1'b1;
                    end
                end
            end
            PULSE: begin
                if (tmr_expire) begin
                    if (GUARD_CYC != 0) begin
                        state_d   = GUARD;
                        tmr_load  = 1'b1;
                        tmr_value = GUARD_VAL;
                    end else begin
                        state_d    = IDLE;
                        done_d     = 1'b1;
                        op_valid_d = 1'b0;
                    end
                end
            end
            GUARD: begin
                if (tmr_expire) begin
                    state_d    = IDLE;
                    // The guard after the power-up pulse carries no request.
                    done_d     = op_valid_q;
                    op_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        s_d     = (state_d == PULSE) && (op_d == OP_SET);
        r_d     = (state_d == INIT_PULSE) || ((state_d == PULSE) && (op_d == OP_RESET));
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            op_q       <= OP_RESET;
            op_valid_q <= 1'b0;
            q_q        <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            q_q        <= q_d;
            s_q        <= s_d;
            r_q        <= r_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign req_ready = ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign q         = q_q;
    assign qbar      = ~q_q;
    assign done      = done_q;

    a_sr_exclusive: assert property (@(posedge clk) !(s_q && r_q));
    a_quiet_states: assert property (@(posedge clk) disable iff (rst)
        (state_q inside {INIT, IDLE, GUARD}) |-> !(s_q || r_q));

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Randomized bench for sr_latch_ctrl: two configurations share one stimulus
// stream and are checked cycle by cycle against a schedule-based reference.
module tb_sr_latch_ctrl;

    localparam int NCYC = 4000;
    localparam int NC   = NCYC + 100;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic reset_req = 1'b0;
    logic [1:0] o_ready, o_s, o_r, o_q, o_qbar, o_done;

    always #5 clk = ~clk;

    sr_latch_ctrl #(.PULSE_CYC(2), .GUARD_CYC(1), .PRIO_SET(1'b1)) u0 (
        .clk(clk), .rst(rst), .set_req(set_req), .reset_req(reset_req),
        .req_ready(o_ready[0]), .s(o_s[0]), .r(o_r[0]), .q(o_q[0]),
        .qbar(o_qbar[0]), .done(o_done[0])
    );

    sr_latch_ctrl #(.PULSE_CYC(3), .GUARD_CYC(0), .PRIO_SET(1'b0)) u1 (
        .clk(clk), .rst(rst), .set_req(set_req), .reset_req(reset_req),
        .req_ready(o_ready[1]), .s(o_s[1]), .r(o_r[1]), .q(o_q[1]),
        .qbar(o_qbar[1]), .done(o_done[1])
    );

    // Reference: per-cycle expected pulse/done timeline plus ready horizon.
    int pc[2] = '{2, 3};
    int gc[2] = '{1, 0};
    bit prio[2] = '{1'b1, 1'b0};
    bit exp_s[2][NC];
    bit exp_r[2][NC];
    bit exp_done[2][NC];
    bit m_q[2];
    bit pending_init[2];
    int ready_from[2];
    bit eq[2];
    bit er[2];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, expv);
    endtask

    task automatic model_step(input int i, input int n, input logic rst_v,
                              input logic set_v, input logic reset_v);
        int p;
        int g;
        bit tgt;
        p = pc[i];
        g = gc[i];
        if (rst_v) begin
            for (int c = n + 1; c < n + 64; c++) begin
                exp_s[i][c]    = 1'b0;
                exp_r[i][c]    = 1'b0;
                exp_done[i][c] = 1'b0;
            end
            m_q[i]          = 1'b0;
            ready_from[i]   = NEVER;
            pending_init[i] = 1'b1;
        end else if (pending_init[i]) begin
            for (int c = n + 1; c <= n + p; c++) exp_r[i][c] = 1'b1;
            ready_from[i]   = n + p + g + 1;
            pending_init[i] = 1'b0;
        end else if (n >= ready_from[i] && (set_v || reset_v)) begin
            tgt = (set_v && reset_v) ? prio[i] : set_v;
            if (tgt == m_q[i]) begin
                exp_done[i][n + 1] = 1'b1;
            end else begin
                m_q[i] = tgt;
                for (int c = n + 1; c <= n + p; c++) begin
                    if (tgt) exp_s[i][c] = 1'b1;
                    else     exp_r[i][c] = 1'b1;
                end
                ready_from[i] = n + p + g + 1;
                exp_done[i][ready_from[i]] = 1'b1;
            end
        end
        eq[i] = m_q[i];
        er[i] = (n + 1 >= ready_from[i]);
    endtask

    initial begin
        int rst_left;
        int pick;
        rst_left = 0;
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 1'b0;
            pending_init[i] = 1'b1;
            ready_from[i] = NEVER;
        end
        #1;
        for (int n = 0; n < NCYC; n++) begin
            if (n < 3) begin
                rst = 1'b1;
            end else if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst = 1'b0;
            end
            pick = $urandom_range(0, 9);
            set_req   = (pick <= 2) || (pick == 6) || (pick == 7);
            reset_req = (pick >= 3 && pick <= 7);

            @(negedge clk);
            if (n > 0) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("u%0d.s@%0d", i, n), o_s[i], exp_s[i][n]);
                    check($sformatf("u%0d.r@%0d", i, n), o_r[i], exp_r[i][n]);
                    check($sformatf("u%0d.done@%0d", i, n), o_done[i], exp_done[i][n]);
                    check($sformatf("u%0d.q@%0d", i, n), o_q[i], eq[i]);
                    check($sformatf("u%0d.qbar@%0d", i, n), o_qbar[i], ~eq[i]);
                    check($sformatf("u%0d.ready@%0d", i, n), o_ready[i], er[i]);
                end
            end
            for (int i = 0; i < 2; i++) model_step(i, n, rst, set_req, reset_req);
            @(posedge clk);
            #1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
